// File: rtl/jump_sequencer.sv
// Jump/power-bar control FSM: turns the jump button and frame ticks into datapath mode strobes,
// runs charge/launch/descend/loss and a lives counter. Define JUMP_AUTO_LAUNCH_EN for auto-launch from HOLD_MAX.
module jump_sequencer #(
  parameter int LIVES        = 3,
  parameter int FLASH_FRAMES = 120,
  parameter int BLINK_FRAMES = 8
`ifdef JUMP_AUTO_LAUNCH_EN
  ,
  parameter int HOLD_FRAMES  = 60
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame,
  input  logic       btn,
  input  logic       start,
  input  logic       p_max,
  input  logic       p_zero,
  input  logic       player_zero,
  input  logic       ground,
  input  logic       keep_fall,
  output logic       power_inc,
  output logic       power_dec,
  output logic       at_max,
  output logic       player_down,
  output logic       falling,
  output logic       flash_loss,
  output logic       blink,
  output logic [2:0] lives,
  output logic       game_over
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHARGE,
    S_HOLD_MAX,
    S_LAUNCH,
    S_DESCEND,
    S_FALL,
    S_LOSS,
    S_OVER
  } state_t;

  localparam logic [6:0] FLASH_CNT  = 7'(FLASH_FRAMES);
  localparam logic [6:0] BLINK_LAST = 7'(BLINK_FRAMES - 1);
  localparam logic [2:0] LIVES_INIT = 3'(LIVES);
`ifdef JUMP_AUTO_LAUNCH_EN
  localparam logic [6:0] HOLD_CNT   = 7'(HOLD_FRAMES);
`endif

  function automatic logic [6:0] sat_inc7(input logic [6:0] v);
    return (v == 7'h7F) ? v : v + 7'd1;
  endfunction

  function automatic logic [2:0] sat_dec3(input logic [2:0] v);
    return (v == 3'd0) ? v : v - 3'd1;
  endfunction

  // Bit order: {power_inc, power_dec, at_max, player_down, falling, flash_loss, game_over}
  function automatic logic [6:0] decode(input state_t s);
    logic [6:0] o;
    o = 7'b0000000;
    case (s)
      S_CHARGE:   o = 7'b1000000;
      S_LAUNCH:   o = 7'b0100000;
      S_HOLD_MAX: o = 7'b0010000;
      S_DESCEND:  o = 7'b0001000;
      S_FALL:     o = 7'b0000100;
      S_LOSS:     o = 7'b0000010;
      S_OVER:     o = 7'b0000001;
      default:    o = 7'b0000000;
    endcase
    return o;
  endfunction

  logic       btn_meta_q, btn_s_q, btn_s_d_q;
  logic       btn_rise;
  state_t     state_q, state_d;
  logic [6:0] frame_cnt_q, frame_cnt_d;
  logic [6:0] blink_ph_q, blink_ph_d;
  logic       blink_q, blink_d;
  logic [2:0] lives_q, lives_d;
  logic [6:0] strobes_q, strobes_d;
  logic       entering;

  assign btn_rise = btn_s_q & ~btn_s_d_q;

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    case (state_q)
      S_IDLE:     if (btn_rise) state_d = S_CHARGE;
      S_CHARGE: begin
        if (!btn_s_q)   state_d = S_LAUNCH;
        else if (p_max) state_d = S_HOLD_MAX;
      end
      S_HOLD_MAX: begin
        if (!btn_s_q) state_d = S_LAUNCH;
`ifdef JUMP_AUTO_LAUNCH_EN
        else if (frame_cnt_q >= HOLD_CNT) state_d = S_LAUNCH;
`endif
      end
      S_LAUNCH:   if (p_zero) state_d = S_DESCEND;
      S_DESCEND: begin
        if (ground)           state_d = S_LOSS;
        else if (keep_fall)   state_d = S_FALL;
        else if (player_zero) state_d = S_IDLE;
      end
      S_FALL:     if (ground) state_d = S_LOSS;
      S_LOSS: begin
        // The flash ends once the full FLASH_FRAMES ticks have been counted.
        if (frame_cnt_q >= FLASH_CNT) begin
          lives_d = sat_dec3(lives_q);
          state_d = (lives_q <= 3'd1) ? S_OVER : S_IDLE;
        end
      end
      S_OVER: begin
        if (start) begin
          state_d = S_IDLE;
          lives_d = LIVES_INIT;
        end
      end
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    entering    = (state_d != state_q);
    frame_cnt_d = frame_cnt_q;
    blink_ph_d  = blink_ph_q;
    blink_d     = blink_q;
    strobes_d   = decode(state_d);

    if (entering) begin
      frame_cnt_d = 7'd0;
      blink_ph_d  = 7'd0;
    end else if (frame && (state_q == S_LOSS || state_q == S_HOLD_MAX)) begin
      frame_cnt_d = sat_inc7(frame_cnt_q);
    end

    // blink_ph tracks frame count mod BLINK_FRAMES without a divider.
    if (state_d != S_LOSS || state_q != S_LOSS) begin
      blink_d = 1'b1;
    end else if (frame) begin
      if (blink_ph_q == 7'd0) blink_d = ~blink_q;
      blink_ph_d = (blink_ph_q >= BLINK_LAST) ? 7'd0 : blink_ph_q + 7'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_meta_q  <= 1'b0;
      btn_s_q     <= 1'b0;
      btn_s_d_q   <= 1'b0;
      state_q     <= S_IDLE;
      frame_cnt_q <= 7'd0;
      blink_ph_q  <= 7'd0;
      blink_q     <= 1'b1;
      lives_q     <= LIVES_INIT;
      strobes_q   <= 7'd0;
    end else begin
      btn_meta_q  <= btn;
      btn_s_q     <= btn_meta_q;
      btn_s_d_q   <= btn_s_q;
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      blink_ph_q  <= blink_ph_d;
      blink_q     <= blink_d;
      lives_q     <= lives_d;
      strobes_q   <= strobes_d;
    end
  end

  assign {power_inc, power_dec, at_max, player_down, falling, flash_loss, game_over} = strobes_q;
  assign blink = blink_q;
  assign lives = lives_q;

endmodule

// File: tb/tb_jump_sequencer.sv
// Directed, table-driven bench for jump_sequencer: vector table for the main flow plus
// hand-written loss, game-over, reset and hold-at-max sequences.
module tb_jump_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame, btn, start, p_max, p_zero, player_zero, ground, keep_fall;
  logic       power_inc, power_dec, at_max, player_down, falling, flash_loss, blink, game_over;
  logic [2:0] lives;

  jump_sequencer dut (
    .clk(clk), .rst_n(rst_n), .frame(frame), .btn(btn), .start(start),
    .p_max(p_max), .p_zero(p_zero), .player_zero(player_zero), .ground(ground), .keep_fall(keep_fall),
    .power_inc(power_inc), .power_dec(power_dec), .at_max(at_max), .player_down(player_down),
    .falling(falling), .flash_loss(flash_loss), .blink(blink), .lives(lives), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // Input bits: {btn, frame, start, p_max, p_zero, player_zero, ground, keep_fall}
  localparam logic [7:0] I_BTN = 8'h80, I_FRM = 8'h40, I_STA = 8'h20, I_PMX = 8'h10;
  localparam logic [7:0] I_PZ  = 8'h08, I_PLZ = 8'h04, I_GND = 8'h02, I_KF  = 8'h01;
  // Output bits: {power_inc, power_dec, at_max, player_down, falling, flash_loss, game_over}
  localparam logic [6:0] O_IDL = 7'b0000000, O_CHG = 7'b1000000, O_LAU = 7'b0100000;
  localparam logic [6:0] O_MAX = 7'b0010000, O_DSC = 7'b0001000, O_FAL = 7'b0000100;
  localparam logic [6:0] O_LOS = 7'b0000010, O_OVR = 7'b0000001;

  typedef struct {
    logic [7:0] in;
    logic [6:0] o;
    logic [2:0] lv;
    logic       bl;
  } vec_t;

  vec_t tbl[24];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic vec_t mk(input logic [7:0] in, input logic [6:0] o, input logic [2:0] lv, input logic bl);
    vec_t v;
    v.in = in; v.o = o; v.lv = lv; v.bl = bl;
    return v;
  endfunction

  task automatic drive(input logic [7:0] v);
    @(negedge clk);
    {btn, frame, start, p_max, p_zero, player_zero, ground, keep_fall} = v;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [6:0] o, input logic [2:0] lv, input logic bl);
    logic [6:0] act;
    act = {power_inc, power_dec, at_max, player_down, falling, flash_loss, game_over};
    n_chk++;
    if (act === o && lives === lv && blink === bl) n_pass++;
    else $display("FAIL %s: got strobes=%b lives=%0d blink=%b, want strobes=%b lives=%0d blink=%b",
                  nm, act, lives, blink, o, lv, bl);
  endtask

  task automatic step(input string nm, input logic [7:0] v, input logic [6:0] o,
                      input logic [2:0] lv, input logic bl);
    drive(v);
    check(nm, o, lv, bl);
  endtask

  // From IDLE with button released: charge, launch, descend, then ground+keep_fall into LOSS.
  task automatic to_loss(input logic [2:0] lv);
    step("tl_idle0", I_BTN, O_IDL, lv, 1'b1);
    step("tl_idle1", I_BTN, O_IDL, lv, 1'b1);
    step("tl_chg",   I_BTN, O_CHG, lv, 1'b1);
    step("tl_chg0",  8'h00, O_CHG, lv, 1'b1);
    step("tl_chg1",  8'h00, O_CHG, lv, 1'b1);
    step("tl_lau",   8'h00, O_LAU, lv, 1'b1);
    step("tl_dsc",   I_PZ,  O_DSC, lv, 1'b1);
    step("tl_gnd_kf", I_GND | I_KF, O_LOS, lv, 1'b1);
  endtask

  // Full flash: 120 ticks, blink toggles at ticks 1, 9, 17, ...; exit the cycle after the last tick.
  task automatic do_loss(input logic [2:0] lv, input logic [6:0] o_after);
    logic bl;
    for (int k = 1; k <= 120; k++) begin
      bl = (((k - 1) / 8) % 2) == 1;
      step($sformatf("loss_tick%0d", k), I_FRM, O_LOS, lv, bl);
    end
    step("loss_exit", 8'h00, o_after, lv - 3'd1, 1'b1);
  endtask

  initial begin
    tbl[0]  = mk(I_BTN,          O_IDL, 3'd3, 1'b1);
    tbl[1]  = mk(I_BTN,          O_IDL, 3'd3, 1'b1);
    tbl[2]  = mk(I_BTN,          O_CHG, 3'd3, 1'b1);
    tbl[3]  = mk(I_BTN | I_PMX,  O_MAX, 3'd3, 1'b1);
    tbl[4]  = mk(I_BTN | I_FRM,  O_MAX, 3'd3, 1'b1);
    tbl[5]  = mk(8'h00,          O_MAX, 3'd3, 1'b1);
    tbl[6]  = mk(8'h00,          O_MAX, 3'd3, 1'b1);
    tbl[7]  = mk(8'h00,          O_LAU, 3'd3, 1'b1);
    tbl[8]  = mk(I_BTN,          O_LAU, 3'd3, 1'b1);
    tbl[9]  = mk(I_BTN | I_PZ,   O_DSC, 3'd3, 1'b1);
    tbl[10] = mk(8'h00,          O_DSC, 3'd3, 1'b1);
    tbl[11] = mk(I_PLZ,          O_IDL, 3'd3, 1'b1);
    tbl[12] = mk(8'h00,          O_IDL, 3'd3, 1'b1);
    tbl[13] = mk(I_BTN,          O_IDL, 3'd3, 1'b1);
    tbl[14] = mk(I_BTN,          O_IDL, 3'd3, 1'b1);
    tbl[15] = mk(I_BTN,          O_CHG, 3'd3, 1'b1);
    tbl[16] = mk(8'h00,          O_CHG, 3'd3, 1'b1);
    tbl[17] = mk(8'h00,          O_CHG, 3'd3, 1'b1);
    tbl[18] = mk(I_PMX,          O_LAU, 3'd3, 1'b1);
    tbl[19] = mk(I_PZ,           O_DSC, 3'd3, 1'b1);
    tbl[20] = mk(I_KF,           O_FAL, 3'd3, 1'b1);
    tbl[21] = mk(8'h00,          O_FAL, 3'd3, 1'b1);
    tbl[22] = mk(I_PLZ,          O_FAL, 3'd3, 1'b1);
    tbl[23] = mk(I_GND,          O_LOS, 3'd3, 1'b1);

    rst_n = 1'b0;
    {btn, frame, start, p_max, p_zero, player_zero, ground, keep_fall} = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_held", O_IDL, 3'd3, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) drive(8'h00);
    check("reset_idle10", O_IDL, 3'd3, 1'b1);

    for (int i = 0; i < 24; i++) step($sformatf("vec%0d", i), tbl[i].in, tbl[i].o, tbl[i].lv, tbl[i].bl);

    do_loss(3'd3, O_IDL);
    step("start_ignored", I_STA, O_IDL, 3'd2, 1'b1);

    to_loss(3'd2);
    do_loss(3'd2, O_IDL);
    to_loss(3'd1);
    do_loss(3'd1, O_OVR);

    for (int i = 0; i < 4; i++) step("over_btn", I_BTN, O_OVR, 3'd0, 1'b1);
    step("over_start", I_BTN | I_STA, O_IDL, 3'd3, 1'b1);
    for (int i = 0; i < 3; i++) step("held_no_rise", I_BTN, O_IDL, 3'd3, 1'b1);
    for (int i = 0; i < 3; i++) step("release", 8'h00, O_IDL, 3'd3, 1'b1);

    to_loss(3'd3);
    do_loss(3'd3, O_IDL);
    to_loss(3'd2);
    step("mid_loss_t1", I_FRM, O_LOS, 3'd2, 1'b0);
    step("mid_loss_t2", I_FRM, O_LOS, 3'd2, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    {btn, frame, start, p_max, p_zero, player_zero, ground, keep_fall} = 8'h00;
    @(posedge clk);
    #1;
    check("reset_mid_loss", O_IDL, 3'd3, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    drive(8'h00);
    check("after_reset", O_IDL, 3'd3, 1'b1);

    step("hold_i0", I_BTN, O_IDL, 3'd3, 1'b1);
    step("hold_i1", I_BTN, O_IDL, 3'd3, 1'b1);
    step("hold_chg", I_BTN, O_CHG, 3'd3, 1'b1);
    step("hold_max", I_BTN | I_PMX, O_MAX, 3'd3, 1'b1);
    for (int k = 1; k <= 60; k++) step($sformatf("hold_tick%0d", k), I_BTN | I_FRM, O_MAX, 3'd3, 1'b1);
`ifdef JUMP_AUTO_LAUNCH_EN
    step("auto_launch", I_BTN, O_LAU, 3'd3, 1'b1);
    step("auto_dsc", I_BTN | I_PZ, O_DSC, 3'd3, 1'b1);
    step("auto_idle", I_BTN | I_PLZ, O_IDL, 3'd3, 1'b1);
    for (int i = 0; i < 3; i++) step("auto_no_rise", I_BTN, O_IDL, 3'd3, 1'b1);
`else
    step("no_auto_launch", I_BTN, O_MAX, 3'd3, 1'b1);
    for (int k = 1; k <= 80; k++) step("hold_more", I_BTN | I_FRM, O_MAX, 3'd3, 1'b1);
    step("hold_rel0", 8'h00, O_MAX, 3'd3, 1'b1);
    step("hold_rel1", 8'h00, O_MAX, 3'd3, 1'b1);
    step("hold_rel_lau", 8'h00, O_LAU, 3'd3, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
